// File: rtl/cajero_pkg.sv
// Shared types and constants for the cash-dispense stage: bill table,
// controller states and abort causes.
package cajero_pkg;

  localparam int N_DENOM = 5;
  localparam logic [7:0] UMBRAL_BAJO = 8'd5;

  // Index 0 is the highest value so a forward scan is greedy.
  localparam logic [31:0] DENOM [N_DENOM] = '{32'd20000, 32'd10000, 32'd5000, 32'd2000, 32'd1000};

  typedef logic [N_DENOM-1:0][7:0] banco_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PLAN,
    DISPENSE,
    WAIT_ACK,
    DONE,
    FAIL
  } estado_t;

  typedef enum logic [1:0] {
    FALLO_MONTO   = 2'b00,
    FALLO_STOCK   = 2'b01,
    FALLO_MAX     = 2'b10,
    FALLO_TIMEOUT = 2'b11
  } fallo_t;

  function automatic logic [31:0] denom_valor(input logic [2:0] idx);
    case (idx)
      3'd0:    denom_valor = DENOM[0];
      3'd1:    denom_valor = DENOM[1];
      3'd2:    denom_valor = DENOM[2];
      3'd3:    denom_valor = DENOM[3];
      3'd4:    denom_valor = DENOM[4];
      default: denom_valor = '0;
    endcase
  endfunction

endpackage

// File: rtl/cajero_plan_billetes.sv
// Greedy bill planner: one decision per cycle, bounded by per-denomination
// stock and the per-delivery bill limit. Nothing moves until the plan is known good.
module cajero_plan_billetes
  import cajero_pkg::*;
#(
  parameter int MAX_BILLETES = 40
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] rem_inicial,
  input  banco_t      stock,
  output banco_t      plan,
  output logic        fin,
  output logic        ok,
  output fallo_t      codigo
);

  localparam logic [7:0] MAX_B = 8'(MAX_BILLETES);

  logic [31:0] rem;
  logic [2:0]  idx;
  logic [7:0]  total;
  logic        activo;
  logic        tomar;

  assign tomar  = (rem >= denom_valor(idx)) && (plan[idx] < stock[idx]) && (total < MAX_B);
  assign fin    = activo && !tomar && (idx == 3'd4);
  assign ok     = (rem == '0);
  assign codigo = (total == MAX_B) ? FALLO_MAX : FALLO_STOCK;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rem    <= '0;
      idx    <= '0;
      total  <= '0;
      plan   <= '0;
      activo <= 1'b0;
    end else if (start) begin
      rem    <= rem_inicial;
      idx    <= '0;
      total  <= '0;
      plan   <= '0;
      activo <= 1'b1;
    end else if (activo) begin
      if (tomar) begin
        rem       <= rem - denom_valor(idx);
        plan[idx] <= plan[idx] + 8'd1;
        total     <= total + 8'd1;
      end else if (idx == 3'd4) begin
        activo <= 1'b0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/cajero_dispensador.sv
// Cash-dispense stage: validates and plans a delivery, then hands bills to the
// mechanism one at a time over STB/ACK while tracking stock.
//
// state    | meaning
// IDLE     | waiting for a request edge; RECARGA honoured here
// CHECK    | amount sanity check
// PLAN     | greedy split running in cajero_plan_billetes
// DISPENSE | pick next denomination (STB low gap)
// WAIT_ACK | STB high, waiting for ACK or timeout
// DONE     | ENTREGA_COMPLETA pulse
// FAIL     | FALLO_ENTREGA pulse, CODIGO_FALLO updated
module cajero_dispensador
  import cajero_pkg::*;
#(
  parameter int N_INICIAL    = 50,
  parameter int MAX_BILLETES = 40,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENTREGAR_DINERO,
  input  logic [31:0] MONTO,
  input  logic        BILLETE_ACK,
  input  logic        RECARGA,
  output logic        BILLETE_STB,
  output logic [2:0]  BILLETE_DENOM,
  output logic        OCUPADO,
  output logic        ENTREGA_COMPLETA,
  output logic        FALLO_ENTREGA,
  output logic [1:0]  CODIGO_FALLO,
  output logic [4:0]  STOCK_BAJO
);

  localparam logic [7:0]  N_INI8      = 8'(N_INICIAL);
  localparam banco_t      STOCK_LLENO = {N_DENOM{N_INI8}};
  localparam logic [15:0] TMO_CARGA   = 16'(ACK_TIMEOUT - 1);

  estado_t     estado, estado_sig;
  fallo_t      fallo_sig;
  logic        ent_q;
  logic        req;
  logic [31:0] rem;
  banco_t      stock;
  banco_t      plan_q;
  banco_t      plan_calc;
  logic [2:0]  denom_q;
  logic [2:0]  sel;
  logic [15:0] tmo;
  logic [1:0]  codigo_q;
  logic [4:0]  bajo_q;
  logic [4:0]  bajo_calc;
  logic        plan_start;
  logic        plan_fin;
  logic        plan_ok;
  fallo_t      plan_cod;
  logic        ultimo;
  logic        monto_invalido;

  // ent_q resets high so a level already high at reset release is not an edge.
  assign req            = ENTREGAR_DINERO & ~ent_q;
  assign monto_invalido = (rem == '0) || ((rem % 32'd1000) != '0);

  cajero_plan_billetes #(
    .MAX_BILLETES(MAX_BILLETES)
  ) u_plan (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (plan_start),
    .rem_inicial(rem),
    .stock      (stock),
    .plan       (plan_calc),
    .fin        (plan_fin),
    .ok         (plan_ok),
    .codigo     (plan_cod)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    fallo_sig  = FALLO_MONTO;
    plan_start = 1'b0;
    case (estado)
      IDLE:     if (req) estado_sig = CHECK;
      CHECK: begin
        if (monto_invalido) begin
          estado_sig = FAIL;
          fallo_sig  = FALLO_MONTO;
        end else begin
          estado_sig = PLAN;
          plan_start = 1'b1;
        end
      end
      PLAN: begin
        if (plan_fin) begin
          if (plan_ok) begin
            estado_sig = DISPENSE;
          end else begin
            estado_sig = FAIL;
            fallo_sig  = plan_cod;
          end
        end
      end
      DISPENSE: estado_sig = WAIT_ACK;
      WAIT_ACK: begin
        if (BILLETE_ACK) begin
          estado_sig = ultimo ? DONE : DISPENSE;
        end else if (tmo == '0) begin
          estado_sig = FAIL;
          fallo_sig  = FALLO_TIMEOUT;
        end
      end
      DONE:     estado_sig = IDLE;
      FAIL:     estado_sig = IDLE;
      default:  estado_sig = IDLE;
    endcase
  end

  // Lowest index with bills left, i.e. highest value first.
  always_comb begin
    sel = 3'd0;
    for (int k = N_DENOM - 1; k >= 0; k--) begin
      if (plan_q[k] != '0) sel = 3'(k);
    end
  end

  always_comb begin
    ultimo = (plan_q[denom_q] == 8'd1);
    for (int k = 0; k < N_DENOM; k++) begin
      if ((3'(k) != denom_q) && (plan_q[k] != '0)) ultimo = 1'b0;
    end
  end

  always_comb begin
    bajo_calc = '0;
    for (int k = 0; k < N_DENOM; k++) begin
      bajo_calc[k] = (stock[k] < UMBRAL_BAJO);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_q    <= 1'b1;
      rem      <= '0;
      stock    <= STOCK_LLENO;
      plan_q   <= '0;
      denom_q  <= '0;
      tmo      <= '0;
      codigo_q <= '0;
      bajo_q   <= '0;
    end else begin
      ent_q  <= ENTREGAR_DINERO;
      bajo_q <= bajo_calc;
      case (estado)
        IDLE: begin
          if (RECARGA) stock <= STOCK_LLENO;
          if (req) begin
            rem      <= MONTO;
            codigo_q <= FALLO_MONTO;
          end
        end
        PLAN: if (plan_fin && plan_ok) plan_q <= plan_calc;
        DISPENSE: begin
          denom_q <= sel;
          tmo     <= TMO_CARGA;
        end
        WAIT_ACK: begin
          if (BILLETE_ACK) begin
            stock[denom_q]  <= stock[denom_q] - 8'd1;
            plan_q[denom_q] <= plan_q[denom_q] - 8'd1;
          end else if (tmo == '0) begin
            plan_q <= '0;
          end else begin
            tmo <= tmo - 16'd1;
          end
        end
        default: ;
      endcase
      if (estado_sig == FAIL) codigo_q <= fallo_sig;
    end
  end

  assign BILLETE_STB      = (estado == WAIT_ACK);
  assign BILLETE_DENOM    = denom_q;
  assign OCUPADO          = (estado != IDLE);
  assign ENTREGA_COMPLETA = (estado == DONE);
  assign FALLO_ENTREGA    = (estado == FAIL);
  assign CODIGO_FALLO     = codigo_q;
  assign STOCK_BAJO       = bajo_q;

endmodule

// File: tb/tb_cajero_dispensador.sv
// Bench for cajero_dispensador: three instances (default, one bill per
// denomination, four-bill limit) driven with the same directed requests.
module tb_cajero_dispensador;

  localparam int ACK_T = 255;

  logic        CLK;
  logic        RESET;
  logic        ent;
  logic        recarga;
  logic        spur;
  logic [31:0] monto;
  logic [2:0]  ack;
  logic [2:0]  stb, ocup, comp, fallo;
  logic [2:0]  denom [3];
  logic [1:0]  cod   [3];
  logic [4:0]  bajo  [3];
  logic [4:0][7:0] st [3];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int reqcyc;
  int hold_after;
  int nini [3] = '{50, 1, 50};
  int maxb [3] = '{40, 40, 4};
  int mstock [3][5];
  int exp_den [3][64];
  int exp_n [3], exp_pos [3], exp_done [3], exp_code [3], first_cyc [3], hold_idx [3];
  int run [3], n_done [3], n_fail [3], ackcnt [3];
  logic [2:0] stb_prev;

  cajero_dispensador #(.N_INICIAL(50), .MAX_BILLETES(40), .ACK_TIMEOUT(ACK_T)) dut_a (
    .CLK(CLK), .RESET(RESET), .ENTREGAR_DINERO(ent), .MONTO(monto), .BILLETE_ACK(ack[0]),
    .RECARGA(recarga), .BILLETE_STB(stb[0]), .BILLETE_DENOM(denom[0]), .OCUPADO(ocup[0]),
    .ENTREGA_COMPLETA(comp[0]), .FALLO_ENTREGA(fallo[0]), .CODIGO_FALLO(cod[0]), .STOCK_BAJO(bajo[0]));
  cajero_dispensador #(.N_INICIAL(1), .MAX_BILLETES(40), .ACK_TIMEOUT(ACK_T)) dut_b (
    .CLK(CLK), .RESET(RESET), .ENTREGAR_DINERO(ent), .MONTO(monto), .BILLETE_ACK(ack[1]),
    .RECARGA(recarga), .BILLETE_STB(stb[1]), .BILLETE_DENOM(denom[1]), .OCUPADO(ocup[1]),
    .ENTREGA_COMPLETA(comp[1]), .FALLO_ENTREGA(fallo[1]), .CODIGO_FALLO(cod[1]), .STOCK_BAJO(bajo[1]));
  cajero_dispensador #(.N_INICIAL(50), .MAX_BILLETES(4), .ACK_TIMEOUT(ACK_T)) dut_c (
    .CLK(CLK), .RESET(RESET), .ENTREGAR_DINERO(ent), .MONTO(monto), .BILLETE_ACK(ack[2]),
    .RECARGA(recarga), .BILLETE_STB(stb[2]), .BILLETE_DENOM(denom[2]), .OCUPADO(ocup[2]),
    .ENTREGA_COMPLETA(comp[2]), .FALLO_ENTREGA(fallo[2]), .CODIGO_FALLO(cod[2]), .STOCK_BAJO(bajo[2]));

  assign st[0] = dut_a.stock;
  assign st[1] = dut_b.stock;
  assign st[2] = dut_c.stock;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input longint got, input longint expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s inst%0d: got %0d expected %0d (t=%0t)", name, k, got, expv, $time);
    end
  endtask

  function automatic int denv(input int i);
    case (i)
      0: return 20000;
      1: return 10000;
      2: return 5000;
      3: return 2000;
      default: return 1000;
    endcase
  endfunction

  function automatic int bajo_model(input int k);
    int b = 0;
    for (int i = 0; i < 5; i++) if (mstock[k][i] < 5) b |= (1 << i);
    return b;
  endfunction

  task automatic reload(input int k);
    for (int i = 0; i < 5; i++) mstock[k][i] = nini[k];
  endtask

  // Greedy split as min(amount/value, stock, remaining allowance) per denomination.
  task automatic predict(input int k, input int m, input int hold);
    int rem, tot, n, acked;
    int pl [5];
    exp_n[k] = 0; exp_pos[k] = 0; hold_idx[k] = -1; first_cyc[k] = 0;
    if (m == 0 || (m % 1000) != 0) begin
      exp_done[k] = 0; exp_code[k] = 0;
      return;
    end
    rem = m; tot = 0;
    for (int i = 0; i < 5; i++) begin
      n = rem / denv(i);
      if (n > mstock[k][i]) n = mstock[k][i];
      if (n > maxb[k] - tot) n = maxb[k] - tot;
      pl[i] = n; rem -= n * denv(i); tot += n;
    end
    if (rem != 0) begin
      exp_done[k] = 0; exp_code[k] = (tot == maxb[k]) ? 2 : 1;
      return;
    end
    first_cyc[k] = reqcyc + tot + 7;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < pl[i]; j++) begin
        exp_den[k][exp_n[k]] = i; exp_n[k]++;
      end
    if (hold < tot) begin
      hold_idx[k] = hold; exp_n[k] = hold + 1; exp_done[k] = 0; exp_code[k] = 3; acked = hold;
    end else begin
      exp_done[k] = 1; exp_code[k] = 0; acked = tot;
    end
    for (int j = 0; j < acked; j++) mstock[k][exp_den[k][j]]--;
  endtask

  // Mechanism model: acks one cycle after each strobe until its allowance runs out.
  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (stb[k] && ackcnt[k] < hold_after) begin
        ack[k] = 1'b1; ackcnt[k]++;
      end else begin
        ack[k] = spur;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      stb_prev = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (stb[k]) begin
          if (!stb_prev[k]) begin
            run[k] = 1;
            check("strobe_expected", k, (exp_pos[k] < exp_n[k]) ? 1 : 0, 1);
            if (exp_pos[k] == 0) check("first_strobe_cycle", k, cyc, first_cyc[k]);
          end else begin
            run[k]++;
          end
          if (exp_pos[k] < exp_n[k]) check("denom", k, denom[k], exp_den[k][exp_pos[k]]);
        end else if (stb_prev[k]) begin
          check("strobe_len", k, run[k], (exp_pos[k] == hold_idx[k]) ? ACK_T : 1);
          exp_pos[k]++;
        end
        if (comp[k]) begin
          n_done[k]++;
          check("done_expected", k, exp_done[k], 1);
          check("done_all_bills", k, exp_pos[k], exp_n[k]);
        end
        if (fallo[k]) begin
          n_fail[k]++;
          check("fail_expected", k, exp_done[k], 0);
          check("fail_code", k, cod[k], exp_code[k]);
        end
        if (stb[k] || comp[k] || fallo[k]) check("busy", k, ocup[k], 1);
        stb_prev[k] = stb[k];
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge CLK);
    while (ocup != '0 && t < 2000) begin
      @(negedge CLK); t++;
    end
    check("idle_in_time", -1, (ocup == '0) ? 1 : 0, 1);
  endtask

  task automatic run_case(input int m, input int hold, input bit rec);
    @(negedge CLK);
    ent = 1'b1; monto = 32'(m); recarga = rec; hold_after = hold; reqcyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rec) reload(k);
      ackcnt[k] = 0; n_done[k] = 0; n_fail[k] = 0;
      predict(k, m, hold);
    end
    @(negedge CLK);
    recarga = 1'b0;
    wait_idle();
    ent = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check("done_count", k, n_done[k], exp_done[k]);
      check("fail_count", k, n_fail[k], 1 - exp_done[k]);
      check("bills_seen", k, exp_pos[k], exp_n[k]);
      for (int i = 0; i < 5; i++) check("stock", k, st[k][i], mstock[k][i]);
      check("stock_bajo", k, bajo[k], bajo_model(k));
    end
  endtask

  task automatic do_recarga();
    @(negedge CLK); recarga = 1'b1;
    @(negedge CLK); recarga = 1'b0;
    for (int k = 0; k < 3; k++) reload(k);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int t;
    int busy;
    RESET = 1'b0; ent = 1'b0; recarga = 1'b0; spur = 1'b0; monto = '0; hold_after = 1000;
    for (int k = 0; k < 3; k++) begin
      reload(k); exp_n[k] = 0; exp_pos[k] = 0; hold_idx[k] = -1; ackcnt[k] = 0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check("rst_ocupado", k, ocup[k], 0);
      check("rst_stb", k, stb[k], 0);
      check("rst_codigo", k, cod[k], 0);
    end
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("low_stock_pin", 1, bajo[1], 5'b11111);

    run_case(38000, 1000, 0);
    for (int i = 0; i < 5; i++) check("pin_stock49", 0, st[0][i], 49);
    check("pin_max_code", 2, cod[2], 2'b10);
    do_recarga();

    run_case(40000, 1000, 0);
    for (int i = 0; i < 5; i++) check("pin_stock1", 1, st[1][i], 1);
    check("pin_stock_code", 1, cod[1], 2'b01);

    spur = 1'b1;
    run_case(1500, 1000, 0);
    spur = 1'b0;
    check("pin_monto_code", 0, cod[0], 2'b00);
    run_case(0, 1000, 0);
    run_case(35000, 1000, 0);
    check("pin_3bills", 2, exp_n[2], 3);

    run_case(30000, 1, 1);
    check("pin_tmo_code", 0, cod[0], 2'b11);
    check("pin_tmo_s0", 0, st[0][0], 49);
    check("pin_tmo_s1", 0, st[0][1], 50);
    do_recarga();
    check("pin_reload_s0", 0, st[0][0], 50);
    check("pin_reload_s1", 0, st[0][1], 50);

    // Asynchronous reset while a bill is being presented.
    @(negedge CLK);
    ent = 1'b1; monto = 32'd20000; hold_after = 0; reqcyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin ackcnt[k] = 0; predict(k, 20000, 0); end
    t = 0;
    while (!stb[0] && t < 100) begin @(negedge CLK); t++; end
    check("strobe_before_reset", 0, stb[0], 1);
    #2 RESET = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("arst_stb", k, stb[k], 0);
      check("arst_ocupado", k, ocup[k], 0);
      check("arst_done", k, comp[k], 0);
      check("arst_fail", k, fallo[k], 0);
      check("arst_codigo", k, cod[k], 0);
      check("arst_bajo", k, bajo[k], 0);
      check("arst_denom", k, denom[k], 0);
      reload(k); exp_n[k] = 0; exp_pos[k] = 0; hold_idx[k] = -1;
      for (int i = 0; i < 5; i++) check("arst_stock", k, st[k][i], nini[k]);
    end
    hold_after = 1000;
    @(negedge CLK);
    RESET = 1'b1;
    busy = 0;
    repeat (20) begin
      @(negedge CLK);
      if (ocup != '0) busy++;
    end
    check("held_level_no_retrigger", -1, busy, 0);
    ent = 1'b0;
    repeat (2) @(negedge CLK);
    run_case(20000, 1000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cajero_dispensador.md
Name: cajero_dispensador

Overview:
Cash-dispense stage directly downstream of the ATM transaction controller. It consumes that controller's ENTREGAR_DINERO and MONTO outputs and splits the amount greedily into colón bills. It checks the split against per-denomination stock and a bill-count limit before any bill moves. It then drives the bill mechanism one bill at a time over a strobe/ack handshake and maintains the stock counters.

Parameters:
N_INICIAL, 50, bills of each denomination loaded at reset and on RECARGA (8-bit counters)
MAX_BILLETES, 40, maximum bills in one delivery
ACK_TIMEOUT, 255, cycles BILLETE_STB may wait for BILLETE_ACK before aborting

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
ENTREGAR_DINERO  in  1  level from controller; the rising edge requests a delivery
MONTO  in  32  amount in colones; latched on the request edge
BILLETE_ACK  in  1  mechanism has taken the presented bill
RECARGA  in  1  reload all stocks to N_INICIAL; honoured only in IDLE
BILLETE_STB  out  1  bill request to the mechanism
BILLETE_DENOM  out  3  denomination index of the requested bill: 0=20000, 1=10000, 2=5000, 3=2000, 4=1000
OCUPADO  out  1  high in every state except IDLE
ENTREGA_COMPLETA  out  1  one-cycle pulse when all bills are delivered
FALLO_ENTREGA  out  1  one-cycle pulse on abort
CODIGO_FALLO  out  2  abort cause; held until the next accepted request
STOCK_BAJO  out  5  bit i high when stock[i] < 5

Behaviour:
- Reset (asynchronous, RESET=0):
  - All outputs 0.
  - All stocks = N_INICIAL; plan counters 0; state IDLE.
  - Reset mid-operation discards the delivery entirely.
- Request detection: rising edge of ENTREGAR_DINERO, from a registered copy of the input.
  - Edges outside IDLE are ignored.
  - A level held high does not retrigger.
- IDLE:
  - On a request edge: latch MONTO into rem (32-bit), clear CODIGO_FALLO, go to CHECK.
  - RECARGA in the same cycle as a request edge: reload first, then accept the request.
- CHECK (1 cycle):
  - MONTO==0 or MONTO mod 1000 != 0 -> FAIL, code 00.
  - Otherwise -> PLAN with index i=0 and bill total=0.
- PLAN: one decision per cycle.
  - If rem >= DENOM[i], plan[i] < stock[i] and total < MAX_BILLETES: rem -= DENOM[i], plan[i]++, total++.
  - Otherwise i++.
  - When i would pass 4:
    - rem==0 -> DISPENSE.
    - rem!=0 and total==MAX_BILLETES -> FAIL, code 10.
    - Any other nonzero rem -> FAIL, code 01.
  - No bill is strobed unless the full plan succeeds.
  - The split is greedy only; a combination missed by greedy is reported as code 01.
- DISPENSE:
  - Choose the lowest i with plan[i] != 0, i.e. highest value first.
  - Next cycle: assert BILLETE_STB with BILLETE_DENOM=i; enter WAIT_ACK; clear the timeout counter.
- WAIT_ACK:
  - BILLETE_STB and BILLETE_DENOM stay stable until BILLETE_ACK is sampled high.
  - On the ack cycle: stock[i]--, plan[i]--, and BILLETE_STB is low on the next cycle.
  - After the ack: all plan zero -> DONE; otherwise DISPENSE.
  - BILLETE_STB is low for at least 1 cycle between bills.
  - An ack while BILLETE_STB is low is ignored.
- Timeout: the counter reaches ACK_TIMEOUT without an ack -> FAIL, code 11.
  - The remaining plan is cleared.
  - Stock reflects only bills actually acked.
- DONE: ENTREGA_COMPLETA pulses 1 cycle, then IDLE.
- FAIL: FALLO_ENTREGA pulses 1 cycle, CODIGO_FALLO is set, then IDLE.
- Latency: request edge -> CHECK (+1) -> PLAN (number of bills + 5 cycles) -> first BILLETE_STB 1 cycle after PLAN exits.
- Stock never underflows, by construction of the plan.
- STOCK_BAJO is registered and updates the cycle after any stock change.

Decomposition:
- Shared package cajero_pkg:
  - Denomination table DENOM[0..4] = 20000, 10000, 5000, 2000, 1000 (32-bit constants).
  - State encoding IDLE / CHECK / PLAN / DISPENSE / WAIT_ACK / DONE / FAIL.
  - Failure codes FALLO_MONTO=00, FALLO_STOCK=01, FALLO_MAX=10, FALLO_TIMEOUT=11.
  - Low-stock threshold 5.
- One natural sub-module: cajero_plan_billetes.
  - Holds the PLAN iteration.
  - Inputs: rem, stocks, start.
  - Outputs: plan[0..4], ok, fail code.
- Stock counters and the handshake stay in the top level.

Test Plan:
- N_INICIAL=50, MONTO=38000, ack 1 cycle after each strobe -> 5 bills with DENOM 0,1,2,3,4 in that order; ENTREGA_COMPLETA pulses once; every stock 49.
- MONTO=1500 -> FALLO_ENTREGA pulses, CODIGO_FALLO=00, BILLETE_STB never asserted; same response for MONTO=0.
- N_INICIAL=1, MONTO=40000 -> greedy plan leaves rem=2000; CODIGO_FALLO=01; no strobes; stocks unchanged at 1.
- MAX_BILLETES=4, MONTO=38000 -> CODIGO_FALLO=10, no strobes; MONTO=35000 succeeds with 3 bills.
- MONTO=30000, ack the first bill, withhold the second -> after 255 cycles CODIGO_FALLO=11; stock[0]=49, stock[1]=50; then RECARGA restores 50/50.
- RESET low while BILLETE_STB=1 -> all outputs 0 asynchronously; stocks reload to N_INICIAL; after release, ENTREGAR_DINERO held high causes no delivery until it toggles low then high.
